// File: rtl/traffic_phase_ctrl.sv
// Signal-head phase sequencer: RED -> GREEN -> YELLOW with a BCD countdown per phase.
// Define TRAFFIC_PED_REQ_EN to build in the pedestrian request / early-GREEN-end logic.
module traffic_phase_ctrl #(
  parameter int unsigned RED_TIME    = 5,
  parameter int unsigned GREEN_TIME  = 9,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned MIN_GREEN   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       hold,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic [1:0] phase,
  output logic [2:0] light,
  output logic [3:0] count,
  output logic       phase_end
);

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } phase_t;

  if (RED_TIME < 1 || RED_TIME > 9) begin : g_bad_red
    $error("RED_TIME must be in 1..9");
  end
  if (GREEN_TIME < 1 || GREEN_TIME > 9) begin : g_bad_green
    $error("GREEN_TIME must be in 1..9");
  end
  if (YELLOW_TIME < 1 || YELLOW_TIME > 9) begin : g_bad_yellow
    $error("YELLOW_TIME must be in 1..9");
  end
  if (MIN_GREEN > GREEN_TIME) begin : g_bad_min_green
    $error("MIN_GREEN must not exceed GREEN_TIME");
  end

  localparam logic [3:0] RED_LOAD    = 4'(RED_TIME);
  localparam logic [3:0] GREEN_LOAD  = 4'(GREEN_TIME);
  localparam logic [3:0] YELLOW_LOAD = 4'(YELLOW_TIME);

  phase_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [2:0] light_q, light_d;
  logic       end_q, end_d;
  logic       advance;
  logic       early_end;
  logic       red_entry;

  assign advance = tick & ~hold;

`ifdef TRAFFIC_PED_REQ_EN
  localparam logic [3:0] EARLY_LIMIT = 4'(GREEN_TIME - MIN_GREEN);

  logic pending_q, pending_d;
  logic ack_q, ack_d;

  // A served request is cleared on RED entry, but a request arriving that same cycle re-arms it.
  always_comb begin
    pending_d = pending_q;
    ack_d     = 1'b0;
    if (red_entry && pending_q) begin
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end
    if (ped_req) pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ack_q     <= ack_d;
    end
  end

  assign early_end = pending_q && (count_q <= EARLY_LIMIT);
  assign ped_ack   = ack_q;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign early_end      = 1'b0;
  assign ped_ack        = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    end_d     = 1'b0;
    red_entry = 1'b0;
    case (state_q)
      RED: begin
        if (advance) begin
          if (count_q == 4'd0) begin
            state_d = GREEN;
            count_d = GREEN_LOAD;
            end_d   = 1'b1;
          end else begin
            count_d = count_q - 4'd1;
          end
        end
      end
      GREEN: begin
        if (advance) begin
          if (count_q == 4'd0 || early_end) begin
            state_d = YELLOW;
            count_d = YELLOW_LOAD;
            end_d   = 1'b1;
          end else begin
            count_d = count_q - 4'd1;
          end
        end
      end
      YELLOW: begin
        if (advance) begin
          if (count_q == 4'd0) begin
            state_d   = RED;
            count_d   = RED_LOAD;
            end_d     = 1'b1;
            red_entry = 1'b1;
          end else begin
            count_d = count_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = RED;
        count_d = RED_LOAD;
      end
    endcase
  end

  always_comb begin
    case (state_d)
      GREEN:   light_d = 3'b001;
      YELLOW:  light_d = 3'b010;
      default: light_d = 3'b100;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RED;
      count_q <= RED_LOAD;
      light_q <= 3'b100;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      light_q <= light_d;
      end_q   <= end_d;
    end
  end

  assign phase     = state_q;
  assign count     = count_q;
  assign light     = light_q;
  assign phase_end = end_q;

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Phase sequencer for the countdown timer datapath. Sequences a signal head through RED → GREEN → YELLOW → RED. Loads each phase's duration into an internal BCD down-counter and decrements it on an external one-second tick. Drives the lamp outputs, the remaining-time digit shown on the 7-segment display, and a pedestrian request/acknowledge handshake.

## Interface
Parameters:
- RED_TIME, default 5: RED duration load value, legal range 1..9.
- GREEN_TIME, default 9: GREEN duration load value, legal range 1..9.
- YELLOW_TIME, default 2: YELLOW duration load value, legal range 1..9.
- MIN_GREEN, default 3: minimum GREEN ticks before a pedestrian request may cut GREEN short. Must satisfy MIN_GREEN ≤ GREEN_TIME.
- Out-of-range parameter values are an elaboration error.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle count enable, nominally 1 Hz.
- hold  in  1  freezes the countdown and phase while high.
- ped_req  in  1  pedestrian request, level or pulse, sampled every cycle.
- ped_ack  out  1  one-cycle pulse when a pending request is served.
- phase  out  2  current phase: 00 RED, 01 GREEN, 10 YELLOW. 11 is unused.
- light  out  3  one-hot lamps {red, yellow, green}.
- count  out  4  remaining time, BCD 0..9.
- phase_end  out  1  one-cycle pulse on each phase change.

## Operation
- FSM states are RED, GREEN and YELLOW. An illegal encoding recovers to RED with count = RED_TIME on the next clock.
- Reset values: phase = RED, count = RED_TIME, light = 100, ped_ack = 0, phase_end = 0, pending = 0.
- An "advance" is a cycle with tick = 1 and hold = 0. No state changes on any other cycle, except pending capture.
- On an advance with count ≠ 0: count ← count − 1.
- On an advance with count = 0: move to the next phase, load that phase's duration, and pulse phase_end.
- Transition order is RED→GREEN, GREEN→YELLOW, YELLOW→RED.
- Each phase therefore lasts (duration + 1) advances, and count displays duration..0.
- light decodes phase: RED → 100, GREEN → 001, YELLOW → 010.
- The counter never wraps: 0 is followed by a reload, never by 15.
- Pedestrian logic (only when compiled in, see Configuration):
  - ped_req = 1 sets a pending flag.
  - On an advance in GREEN with pending = 1 and count ≤ GREEN_TIME − MIN_GREEN, GREEN ends early. The block goes to YELLOW, loads YELLOW_TIME, and pulses phase_end. This applies even when count ≠ 0.
  - On every entry into RED with pending = 1: clear pending and pulse ped_ack.
  - If ped_req = 1 in the same cycle as the clear, pending re-arms. The new request is served in the following GREEN.
- Simultaneous events:
  - reset beats everything.
  - hold beats tick.
  - An early-GREEN-end and a normal count = 0 advance in the same cycle produce a single transition and a single phase_end.

## Timing
- All outputs are registered. Reset takes effect on the first rising edge with reset = 1. Outputs show reset values in the cycle after that edge.
- count, phase, light, phase_end and ped_ack update in the cycle after the advancing edge. phase_end is coincident with the new phase values.
- Latency from advance to visible count change is 1 clock.
- ped_req to pending capture takes 1 clock. A pending request affects only advances that occur after the capture edge.
- Full cycle with default parameters and no request: 6 + 10 + 3 = 19 advances.

## Configuration
- Macro: TRAFFIC_PED_REQ_EN.
- Defined: the pending flag, early-GREEN-end logic and ped_ack generation are present.
- Undefined: ped_req is ignored and ped_ack is tied to 0. GREEN always lasts GREEN_TIME + 1 advances.

## Test plan
- Reset: assert reset for 2 cycles, then release → phase = 00, count = 5, light = 100, phase_end = 0, ped_ack = 0.
- Free run: tick = 1 every cycle, hold = 0, defaults → count sequence 5..0, 9..0, 2..0, 5…; phase_end pulses exactly 3 times per 19 advances; light follows 100→001→010→100.
- Hold: in GREEN at count = 3, hold = 1 for 4 ticks → count stays 3 and phase stays 01; release → next advance gives count = 2.
- Pedestrian request (macro defined): 1-cycle ped_req pulse at GREEN entry (count = 9) → the advance at count = 6 goes to YELLOW with count = 2 and pulses phase_end; on the following RED entry, ped_ack = 1 for exactly 1 cycle.
- Reset mid-operation: reset = 1 with tick = 1 in GREEN at count = 4 → next cycle shows phase = RED, count = 5, with no phase_end pulse.
- Macro undefined: repeat the pedestrian-request stimulus → GREEN runs 9..0 for the full 10 advances and ped_ack stays 0.
